// File: rtl/rssi_shift_ctrl.sv
// Closed-loop RX gain-shift controller: block-averages periodic RSSI samples and
// steps the shift (0..4) with hysteresis, applying changes only while the receiver is idle.
module rssi_shift_ctrl #(
    parameter int unsigned SAMPLE_PERIOD = 1024,
    parameter int unsigned LOG2_AVG_LEN  = 4,
    parameter logic [15:0] B1            = 16'd5300,
    parameter logic [15:0] B2            = 16'd4200,
    parameter logic [15:0] B3            = 16'd3100,
    parameter logic [15:0] B4            = 16'd2000,
    parameter logic [15:0] HYST          = 16'd200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        soft_clr,
    input  logic [15:0] rssi,
    input  logic        rx_busy,
    output logic [2:0]  num_shift,
    output logic        shift_upd,
    output logic [15:0] avg_out,
    output logic        avg_valid,
    output logic        pending
);

    localparam int unsigned TW = $clog2(SAMPLE_PERIOD);
    localparam int unsigned CW = LOG2_AVG_LEN + 1;
    localparam int unsigned AW = 16 + LOG2_AVG_LEN;
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'((1 << LOG2_AVG_LEN) - 1);

    typedef enum logic [1:0] {ACC, EVAL, PEND} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [15:0]     avg_q, avg_d;
    logic            avg_valid_q, avg_valid_d;
    logic [2:0]      num_shift_q, num_shift_d;
    logic            shift_upd_q, shift_upd_d;
    logic [2:0]      pend_val_q, pend_val_d;
    logic            pending_q, pending_d;

    logic            terminal;
    logic            blockDone;
    logic [AW-1:0]   accSum;
    logic signed [16:0] incThr;
    logic [16:0]     decThr;
    logic [2:0]      target;

    function automatic logic [15:0] boundary(input logic [2:0] idx);
        case (idx)
            3'd1:    boundary = B1;
            3'd2:    boundary = B2;
            3'd3:    boundary = B3;
            3'd4:    boundary = B4;
            default: boundary = 16'd0;
        endcase
    endfunction

    // Thresholds are widened so a negative or >65535 bound can never cause a step.
    always_comb begin
        terminal  = (timer_q == TIMER_LAST);
        blockDone = terminal && (cnt_q == CNT_LAST);
        accSum    = acc_q + AW'(rssi);
        incThr    = $signed({1'b0, boundary(num_shift_q + 3'd1)}) - $signed({1'b0, HYST});
        decThr    = {1'b0, boundary(num_shift_q)} + {1'b0, HYST};
        target    = num_shift_q;
        if ((num_shift_q < 3'd4) && ($signed({1'b0, avg_q}) < incThr))
            target = num_shift_q + 3'd1;
        else if ((num_shift_q != 3'd0) && ({1'b0, avg_q} >= decThr))
            target = num_shift_q - 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            timer_q     <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            num_shift_q <= 3'd0;
            shift_upd_q <= 1'b0;
            pend_val_q  <= 3'd0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            num_shift_q <= num_shift_d;
            shift_upd_q <= shift_upd_d;
            pend_val_q  <= pend_val_d;
            pending_q   <= pending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (soft_clr || !en) begin
            state_d = ACC;
        end else begin
            case (state_q)
                ACC:     if (blockDone) state_d = EVAL;
                EVAL:    state_d = (target != num_shift_q) ? PEND : ACC;
                PEND:    if (!rx_busy) state_d = ACC;
                default: state_d = ACC;
            endcase
        end
    end

    // soft_clr outranks en; in PEND the timer keeps running but samples are dropped.
    always_comb begin
        timer_d     = terminal ? '0 : timer_q + 1'b1;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        num_shift_d = num_shift_q;
        shift_upd_d = 1'b0;
        pend_val_d  = pend_val_q;
        pending_d   = pending_q;
        if (soft_clr) begin
            timer_d     = '0;
            cnt_d       = '0;
            acc_d       = '0;
            pending_d   = 1'b0;
            num_shift_d = 3'd0;
            shift_upd_d = (num_shift_q != 3'd0);
        end else if (!en) begin
            timer_d   = '0;
            cnt_d     = '0;
            acc_d     = '0;
            pending_d = 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (terminal) begin
                        acc_d = accSum;
                        cnt_d = cnt_q + 1'b1;
                        if (blockDone) begin
                            avg_d       = 16'(accSum >> LOG2_AVG_LEN);
                            avg_valid_d = 1'b1;
                        end
                    end
                end
                EVAL: begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (target != num_shift_q) begin
                        pend_val_d = target;
                        pending_d  = 1'b1;
                    end
                end
                PEND: begin
                    if (!rx_busy) begin
                        num_shift_d = pend_val_q;
                        shift_upd_d = 1'b1;
                        pending_d   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        num_shift = num_shift_q;
        shift_upd = shift_upd_q;
        avg_out   = avg_q;
        avg_valid = avg_valid_q;
        pending   = pending_q;
    end

endmodule

// File: doc/rssi_shift_ctrl.md
Name: rssi_shift_ctrl

Overview:
Closed-loop controller for the receive-path gain shifter. It periodically samples the 16-bit RSSI and block-averages the samples. It then moves the shift amount (0..4) one step at a time, with hysteresis. Each new shift is applied only when the receiver is idle, via a pending/apply handshake, so the datapath shift never changes mid-packet.

Parameters:
SAMPLE_PERIOD, 1024, clk cycles between RSSI samples (>=2)
LOG2_AVG_LEN, 4, log2 of the number of samples per average block
B1, 5300, shift>=1 region boundary (avg below this, about 6 dB)
B2, 4200, shift>=2 boundary (12 dB)
B3, 3100, shift>=3 boundary (18 dB)
B4, 2000, shift=4 boundary (24 dB)
HYST, 200, hysteresis margin in RSSI units

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
en  in  1  loop enable; low clears sampling and pending state, holds num_shift
soft_clr  in  1  synchronous one-cycle request: num_shift to 0, restart loop
rssi  in  16  unsigned RSSI, sampled on timer terminal count
rx_busy  in  1  high while a packet is in flight; no shift change allowed
num_shift  out  3  applied shift, 0..4
shift_upd  out  1  one-cycle pulse in the cycle num_shift takes a new value
avg_out  out  16  last block average, acc >> LOG2_AVG_LEN
avg_valid  out  1  one-cycle pulse when avg_out updates
pending  out  1  high while a decided shift waits for rx_busy low

Behaviour:
- Reset values: num_shift=0, shift_upd=0, avg_out=0, avg_valid=0, pending=0. Internally: state=ACC, timer=0, sample count=0, acc=0.
- Accumulator width is 16+LOG2_AVG_LEN and cannot overflow. The average is truncated (floor).
- The sample timer counts 0..SAMPLE_PERIOD-1 and wraps. It runs in every state while en=1.
- State ACC:
  - On a timer terminal cycle (count=SAMPLE_PERIOD-1), add rssi to acc and increment the sample count.
  - When the 2^LOG2_AVG_LEN-th sample is added at cycle t, avg_out is loaded and avg_valid pulses at t+1. The state is EVAL at t+1.
- State EVAL (one cycle). Let s = current num_shift.
  - If s<4 and avg < B(s+1)-HYST, then target = s+1.
  - Else if s>0 and avg >= B(s)+HYST, then target = s-1.
  - Else target = s.
  - Boundary check uses strict < on the way down, >= on the way up.
  - Only one step per evaluation.
  - If target = s, go to ACC. Otherwise latch target into pend_val, go to PEND, and assert pending from t+2.
  - In both cases acc and the sample count are cleared.
- State PEND:
  - Accumulation is suspended; timer terminal counts are ignored.
  - In the first cycle with rx_busy=0: num_shift <= pend_val, shift_upd pulses, pending drops, and the state goes to ACC.
  - Earliest apply: num_shift is visible at t+3.
  - rx_busy high holds PEND indefinitely. There is no timeout.
- Arithmetic guards:
  - B(s+1)-HYST is computed signed (17 bits). A negative result never triggers a step.
  - B(s)+HYST is computed 17 bits wide. A result above 65535 never triggers a step.
- en=0: state forced to ACC; acc, sample count, timer and pending cleared. num_shift and avg_out hold, and there is no shift_upd.
- soft_clr=1 (takes priority over en and all states):
  - num_shift <= 0, with a shift_upd pulse only if num_shift was nonzero.
  - acc, sample count, timer and pending cleared; state goes to ACC.
- rssi is sampled only on a timer terminal cycle. Values in other cycles have no effect.
- num_shift never leaves 0..4.
- Async reset mid-PEND discards pend_val with no shift_upd.

Test Plan:
1. Downward steps. Bench overrides SAMPLE_PERIOD=8, LOG2_AVG_LEN=2. Hold rssi=1500, rx_busy=0 from reset. Required: avg_out=1500 with avg_valid at cycle 33. num_shift steps 0 to 1 to 2 to 3 to 4, one step per 32-cycle block, each with a single shift_upd pulse. num_shift stays at 4 afterwards with no further pulses.
2. Hysteresis. Bring num_shift to 1, then hold rssi=5400 (B1+100). num_shift stays 1. Then rssi=5500 (>=B1+HYST): num_shift goes to 0 after the next block. rssi=5150 from shift 0 gives no step; rssi=5099 gives a step to 1.
3. Gating. Decide a step with rx_busy=1 held for 200 cycles. pending stays high, num_shift is unchanged and samples are ignored. Drop rx_busy: num_shift updates on the next edge, shift_upd pulses once, pending goes to 0.
4. Soft clear. At num_shift=3 mid-PEND, pulse soft_clr. num_shift goes to 0, shift_upd pulses, pending goes to 0, and the first subsequent avg_valid occurs a full block later. With num_shift=0, soft_clr produces no shift_upd.
5. Enable and reset. Drop en mid-block. Required: no avg_valid and num_shift held. Re-enable: a full block is needed before avg_valid. Assert rst_n low asynchronously mid-PEND: all outputs go to 0 immediately.
6. Boundary. rssi=0: num_shift saturates at 4. rssi=65535 from shift 4: steps down to 0 with no wrap.
